// File: rtl/s_memory_phase_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | s_memory_phase_sequencer_pkg                                               |
// | S-memory owner encodings and sequencer state type, shared with the mux.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package s_memory_phase_sequencer_pkg;

    localparam logic [1:0] SEL_NONE    = 2'b00;
    localparam logic [1:0] SEL_INIT    = 2'b01;
    localparam logic [1:0] SEL_SHUFFLE = 2'b10;
    localparam logic [1:0] SEL_DECODE  = 2'b11;

    localparam int SECRET_KEY_WIDTH = 24;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        INIT_RUN    = 3'd1,
        SHUFFLE_RUN = 3'd2,
        DECODE_RUN  = 3'd3,
        FOUND       = 3'd4,
        EXHAUSTED   = 3'd5,
        FAULT       = 3'd6
    } seq_state_t;

    function automatic logic [1:0] sel_for_state(input seq_state_t s);
        logic [1:0] sel;
        sel = SEL_NONE;
        case (s)
            INIT_RUN:    sel = SEL_INIT;
            SHUFFLE_RUN: sel = SEL_SHUFFLE;
            DECODE_RUN:  sel = SEL_DECODE;
            default:     sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/s_memory_phase_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | s_memory_phase_sequencer                                                   |
// | Steps init/shuffle/decode per candidate key until a key decodes or the     |
// | key space runs out. Optional per-phase watchdog: S_SEQ_WATCHDOG_EN.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module s_memory_phase_sequencer
    import s_memory_phase_sequencer_pkg::*;
#(
    parameter int KEY_WIDTH       = 22,
    parameter int WATCHDOG_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        init_done,
    input  logic        shuffle_done,
    input  logic        decode_done,
    input  logic        decode_key_valid,
    output logic        init_start,
    output logic        shuffle_start,
    output logic        decode_start,
    output logic [1:0]  select_share,
    output logic [23:0] secret_key,
    output logic        busy,
    output logic        key_found,
    output logic        key_exhausted,
    output logic        watchdog_error
);

    localparam logic [23:0] KEY_MAX = 24'((32'd1 << KEY_WIDTH) - 32'd1);

    if (KEY_WIDTH < 1 || KEY_WIDTH > SECRET_KEY_WIDTH || WATCHDOG_CYCLES < 1) begin : g_param_check
        $error("s_memory_phase_sequencer: KEY_WIDTH must be 1..24 and WATCHDOG_CYCLES >= 1");
    end

    seq_state_t  state;
    seq_state_t  next_state;
    logic        phase_entry;
    logic        next_entry;
    logic [23:0] next_key;

    // phase_entry marks the first cycle of a RUN state; done strobes seen then are stale.
    assign init_start    = phase_entry && (state == INIT_RUN);
    assign shuffle_start = phase_entry && (state == SHUFFLE_RUN);
    assign decode_start  = phase_entry && (state == DECODE_RUN);
    assign select_share  = sel_for_state(state);
    assign busy          = (state == INIT_RUN) || (state == SHUFFLE_RUN) || (state == DECODE_RUN);

`ifdef S_SEQ_WATCHDOG_EN
    localparam int            WD_W     = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WATCHDOG_CYCLES - 1);

    logic [WD_W-1:0] wd_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_count <= '0;
        end else if (next_entry) begin
            wd_count <= '0;
        end else if (busy) begin
            wd_count <= wd_count + 1'b1;
        end
    end

    assign watchdog_error = (state == FAULT);
`else
    assign watchdog_error = 1'b0;
`endif

    always_comb begin
        next_state = state;
        next_entry = 1'b0;
        next_key   = secret_key;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = INIT_RUN;
                    next_entry = 1'b1;
                end
            end
            INIT_RUN: begin
                if (!phase_entry && init_done) begin
                    next_state = SHUFFLE_RUN;
                    next_entry = 1'b1;
                end
            end
            SHUFFLE_RUN: begin
                if (!phase_entry && shuffle_done) begin
                    next_state = DECODE_RUN;
                    next_entry = 1'b1;
                end
            end
            DECODE_RUN: begin
                if (!phase_entry && decode_done) begin
                    if (decode_key_valid) begin
                        next_state = FOUND;
                    end else if (secret_key < KEY_MAX) begin
                        next_key   = secret_key + 24'd1;
                        next_state = INIT_RUN;
                        next_entry = 1'b1;
                    end else begin
                        next_state = EXHAUSTED;
                    end
                end
            end
            default: begin
                next_state = state;
            end
        endcase
`ifdef S_SEQ_WATCHDOG_EN
        // A legitimate done on the last allowed cycle still wins over the timeout.
        if (busy && (next_state == state) && !next_entry && (wd_count == WD_LIMIT)) begin
            next_state = FAULT;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            phase_entry   <= 1'b0;
            secret_key    <= '0;
            key_found     <= 1'b0;
            key_exhausted <= 1'b0;
        end else begin
            state         <= next_state;
            phase_entry   <= next_entry;
            secret_key    <= next_key;
            key_found     <= (next_state == FOUND);
            key_exhausted <= (next_state == EXHAUSTED);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_s_memory_phase_sequencer.sv
`default_nettype none
// Directed bench: table of per-cycle vectors plus hand sequences for key
// rounds, exhaustion, asynchronous reset and the optional watchdog.
module tb_s_memory_phase_sequencer;

    typedef struct packed {
        logic        is;
        logic        ss;
        logic        ds;
        logic [1:0]  sel;
        logic        busy;
        logic        found;
        logic        exh;
        logic        wderr;
        logic [23:0] key;
    } obs_t;

    typedef struct packed {
        logic rn, st, id, sd, dd, kv;
        obs_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, init_done = 1'b0, shuffle_done = 1'b0;
    logic        decode_done = 1'b0, decode_key_valid = 1'b0;

    logic        init_start, shuffle_start, decode_start, busy, key_found, key_exhausted, watchdog_error;
    logic [1:0]  select_share;
    logic [23:0] secret_key;

    logic        b_init_start, b_shuffle_start, b_decode_start, b_busy, b_key_found, b_key_exhausted, b_watchdog_error;
    logic [1:0]  b_select_share;
    logic [23:0] b_secret_key;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    s_memory_phase_sequencer #(.KEY_WIDTH(2), .WATCHDOG_CYCLES(16)) u_small (
        .clk(clk), .reset_n(reset_n), .start(start), .init_done(init_done),
        .shuffle_done(shuffle_done), .decode_done(decode_done), .decode_key_valid(decode_key_valid),
        .init_start(init_start), .shuffle_start(shuffle_start), .decode_start(decode_start),
        .select_share(select_share), .secret_key(secret_key), .busy(busy),
        .key_found(key_found), .key_exhausted(key_exhausted), .watchdog_error(watchdog_error)
    );

    s_memory_phase_sequencer #(.WATCHDOG_CYCLES(16)) u_big (
        .clk(clk), .reset_n(reset_n), .start(start), .init_done(init_done),
        .shuffle_done(shuffle_done), .decode_done(decode_done), .decode_key_valid(decode_key_valid),
        .init_start(b_init_start), .shuffle_start(b_shuffle_start), .decode_start(b_decode_start),
        .select_share(b_select_share), .secret_key(b_secret_key), .busy(b_busy),
        .key_found(b_key_found), .key_exhausted(b_key_exhausted), .watchdog_error(b_watchdog_error)
    );

    function automatic obs_t act_small();
        obs_t o;
        o.is = init_start; o.ss = shuffle_start; o.ds = decode_start;
        o.sel = select_share; o.busy = busy; o.found = key_found;
        o.exh = key_exhausted; o.wderr = watchdog_error; o.key = secret_key;
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic rn, st, id, sd, dd, kv,
                        input logic is, ss, ds, input logic [1:0] sel,
                        input logic bz, fnd, exh, input logic [23:0] key);
        vec_t v;
        v.rn = rn; v.st = st; v.id = id; v.sd = sd; v.dd = dd; v.kv = kv;
        v.exp.is = is; v.exp.ss = ss; v.exp.ds = ds; v.exp.sel = sel;
        v.exp.busy = bz; v.exp.found = fnd; v.exp.exh = exh; v.exp.wderr = 1'b0; v.exp.key = key;
        vecs.push_back(v);
    endtask

    task automatic step(input logic st, id, sd, dd, kv);
        start = st; init_done = id; shuffle_done = sd; decode_done = dd; decode_key_valid = kv;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        quiet(1);
        reset_n = 1'b1;
    endtask

    // Entered with init_start visible; leaves with the decode verdict applied.
    task automatic round(input logic kv);
        quiet(5); step(0, 1, 0, 0, 0);
        quiet(5); step(0, 0, 1, 0, 0);
        quiet(5); step(0, 0, 0, 1, kv);
    endtask

    initial begin
        // Single key found on the first round, done returned 5 cycles after each start.
        push(0, 0,0,0,0,0, 0,0,0,2'b00, 0,0,0, 24'd0);
        push(1, 0,0,0,0,0, 0,0,0,2'b00, 0,0,0, 24'd0);
        push(1, 1,0,0,0,0, 1,0,0,2'b01, 1,0,0, 24'd0);
        for (int k = 0; k < 5; k++) push(1, 0,0,0,0,0, 0,0,0,2'b01, 1,0,0, 24'd0);
        push(1, 0,1,0,0,0, 0,1,0,2'b10, 1,0,0, 24'd0);
        for (int k = 0; k < 5; k++) push(1, 0,0,0,0,0, 0,0,0,2'b10, 1,0,0, 24'd0);
        push(1, 0,0,1,0,0, 0,0,1,2'b11, 1,0,0, 24'd0);
        for (int k = 0; k < 5; k++) push(1, 0,0,0,0,0, 0,0,0,2'b11, 1,0,0, 24'd0);
        push(1, 0,0,0,1,1, 0,0,0,2'b00, 0,1,0, 24'd0);
        push(1, 1,0,0,0,0, 0,0,0,2'b00, 0,1,0, 24'd0);
        // Stray strobes: inactive-phase dones, done during the start pulse, start while running.
        push(0, 0,0,0,0,0, 0,0,0,2'b00, 0,0,0, 24'd0);
        push(1, 1,0,0,0,0, 1,0,0,2'b01, 1,0,0, 24'd0);
        push(1, 0,1,0,0,0, 0,0,0,2'b01, 1,0,0, 24'd0);
        push(1, 0,0,1,0,0, 0,0,0,2'b01, 1,0,0, 24'd0);
        push(1, 0,0,0,1,1, 0,0,0,2'b01, 1,0,0, 24'd0);
        push(1, 0,0,0,0,0, 0,0,0,2'b01, 1,0,0, 24'd0);
        push(1, 0,1,0,0,0, 0,1,0,2'b10, 1,0,0, 24'd0);
        push(1, 1,0,0,0,0, 0,0,0,2'b10, 1,0,0, 24'd0);
        push(1, 1,0,0,0,0, 0,0,0,2'b10, 1,0,0, 24'd0);
        push(1, 0,0,1,0,0, 0,0,1,2'b11, 1,0,0, 24'd0);
        push(1, 0,0,0,0,0, 0,0,0,2'b11, 1,0,0, 24'd0);
        push(1, 0,0,0,1,0, 1,0,0,2'b01, 1,0,0, 24'd1);
        push(1, 0,1,0,0,0, 0,0,0,2'b01, 1,0,0, 24'd1);
        push(0, 0,0,0,0,0, 0,0,0,2'b00, 0,0,0, 24'd0);

        #1;
        chk("reset_state", act_small(), 33'd0);
        for (int i = 0; i < vecs.size(); i++) begin
            reset_n = vecs[i].rn;
            step(vecs[i].st, vecs[i].id, vecs[i].sd, vecs[i].dd, vecs[i].kv);
            chk($sformatf("vec%0d", i), act_small(), vecs[i].exp);
        end

        // Keys 0..2 rejected, key 3 accepted.
        do_reset();
        step(1, 0, 0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("round%0d_init_start", r), {init_start, secret_key}, {1'b1, 24'(r)});
            round(r == 3);
        end
        chk("found_small", {key_found, busy, select_share, secret_key}, {1'b1, 1'b0, 2'b00, 24'h000003});
        chk("found_big", {b_key_found, b_secret_key}, {1'b1, 24'h000003});

        // KEY_WIDTH=2 exhausts after 4 rounds; the wide instance keeps counting.
        do_reset();
        step(1, 0, 0, 0, 0);
        for (int r = 0; r < 4; r++) round(1'b0);
        chk("exhausted", {key_exhausted, key_found, busy, select_share, secret_key},
            {1'b1, 1'b0, 1'b0, 2'b00, 24'd3});
        chk("big_key4", {b_init_start, b_busy, b_secret_key}, {1'b1, 1'b1, 24'd4});
        round(1'b0);
        chk("exhausted_holds", {key_exhausted, secret_key}, {1'b1, 24'd3});
        chk("big_key5", b_secret_key, 24'd5);
        quiet(5); step(0, 1, 0, 0, 0);
        quiet(5); step(0, 0, 1, 0, 0);
        quiet(2);
        chk("big_in_decode", {b_select_share, b_busy}, {2'b11, 1'b1});

        // Mid-cycle asynchronous reset.
        #3 reset_n = 1'b0;
        #1;
        chk("async_clear_big", {b_select_share, b_busy, b_decode_start, b_secret_key}, 28'd0);
        chk("async_clear_small", act_small(), 33'd0);
        quiet(1);
        reset_n = 1'b1;
        quiet(1);
        chk("release_no_glitch", {b_init_start, b_shuffle_start, b_decode_start, b_select_share, b_busy,
                                  init_start, select_share}, 10'd0);
        quiet(1);
        chk("release_idle", {b_select_share, b_secret_key, select_share, busy}, 29'd0);

        // Withheld shuffle_done.
        do_reset();
        step(1, 0, 0, 0, 0);
        quiet(5);
        step(0, 1, 0, 0, 0);
        begin
            int shuffle_cycles;
            shuffle_cycles = (select_share == 2'b10) ? 1 : 0;
            for (int k = 0; k < 15; k++) begin
                quiet(1);
                if (select_share == 2'b10) shuffle_cycles++;
            end
            chk("shuffle_cycles", shuffle_cycles, 16);
        end
        quiet(1);
`ifdef S_SEQ_WATCHDOG_EN
        chk("wd_fault", {watchdog_error, select_share, busy, b_watchdog_error, b_select_share},
            {1'b1, 2'b00, 1'b0, 1'b1, 2'b00});
        quiet(3);
        chk("wd_fault_terminal", {watchdog_error, busy, shuffle_start}, {1'b1, 1'b0, 1'b0});
`else
        chk("no_wd", {watchdog_error, select_share, busy, b_watchdog_error}, {1'b0, 2'b10, 1'b1, 1'b0});
        quiet(40);
        chk("no_wd_long", {watchdog_error, select_share, busy}, {1'b0, 2'b10, 1'b1});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
